// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO on clk, decodes frames addressed
// to PHY_ADDR and bridges them to a 32x16 register block via one-clk strobes.
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR = 5'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic [15:0] wr_data,
    output logic        wr_stb,
    output logic        rd_stb,
    input  logic [15:0] rd_data
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned HDR_W  = 12;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam logic [CNT_W-1:0] BIT_REGAD_LSB = CNT_W'(13);
    localparam logic [CNT_W-1:0] BIT_LAST      = CNT_W'(31);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST1,
        S_HEADER,
        S_WDATA,
        S_RDATA,
        S_SKIP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [2:0]           mdc_sync;
    logic [1:0]           mdio_sync;
    logic [HDR_W-2:0]     hdr_shift;
    logic [DATA_W-2:0]    data_shift;
    logic [DATA_W-1:0]    tx_shift;
    logic                 rd_load;

    logic                 mdc_fall_c;
    logic                 mdc_rise_c;
    logic                 bit_in_c;
    logic [HDR_W-1:0]     hdr_word_c;
    logic [1:0]           hdr_op_c;
    logic [ADDR_W-1:0]    hdr_phy_c;
    logic [ADDR_W-1:0]    hdr_reg_c;

    // Two-flop synchronizers; the third mdc flop gives edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdc_sync  <= 3'b000;
            mdio_sync <= 2'b11;
        end else begin
            mdc_sync  <= {mdc_sync[1:0], mdc};
            mdio_sync <= {mdio_sync[0], mdio_in};
        end
    end

    assign mdc_fall_c = mdc_sync[2] & ~mdc_sync[1];
    assign mdc_rise_c = ~mdc_sync[2] & mdc_sync[1];
    assign bit_in_c   = mdio_sync[1];

    // Header word as it stands once bit 13 is sampled.
    assign hdr_word_c = {hdr_shift, bit_in_c};
    assign hdr_op_c   = hdr_word_c[11:10];
    assign hdr_phy_c  = hdr_word_c[9:5];
    assign hdr_reg_c  = hdr_word_c[4:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            hdr_shift  <= '0;
            data_shift <= '0;
            tx_shift   <= '0;
            rd_load    <= 1'b0;
            mdio_out   <= 1'b0;
            mdio_oe    <= 1'b0;
            reg_addr   <= '0;
            wr_data    <= '0;
            wr_stb     <= 1'b0;
            rd_stb     <= 1'b0;
        end else begin
            wr_stb  <= 1'b0;
            rd_stb  <= 1'b0;
            rd_load <= rd_stb;
            if (rd_load) begin
                tx_shift <= rd_data;
            end

            case (state)
                S_IDLE: begin
                    if (mdc_fall_c && !bit_in_c) begin
                        state   <= S_ST1;
                        bit_cnt <= CNT_W'(1);
                    end
                end

                // A repeated 0 is taken as a fresh ST bit 0.
                S_ST1: begin
                    if (mdc_fall_c) begin
                        if (bit_in_c) begin
                            state   <= S_HEADER;
                            bit_cnt <= CNT_W'(2);
                        end else begin
                            bit_cnt <= CNT_W'(1);
                        end
                    end
                end

                S_HEADER: begin
                    if (mdc_fall_c) begin
                        hdr_shift <= hdr_word_c[HDR_W-2:0];
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == BIT_REGAD_LSB) begin
                            if (hdr_phy_c == PHY_ADDR && hdr_op_c == OP_WRITE) begin
                                reg_addr <= hdr_reg_c;
                                state    <= S_WDATA;
                            end else if (hdr_phy_c == PHY_ADDR && hdr_op_c == OP_READ) begin
                                reg_addr <= hdr_reg_c;
                                rd_stb   <= 1'b1;
                                state    <= S_RDATA;
                            end else begin
                                state <= S_SKIP;
                            end
                        end
                    end
                end

                S_WDATA: begin
                    if (mdc_fall_c) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt[4]) begin
                            data_shift <= {data_shift[DATA_W-3:0], bit_in_c};
                        end
                        if (bit_cnt == BIT_LAST) begin
                            wr_data <= {data_shift, bit_in_c};
                            wr_stb  <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end

                // bit_cnt wraps to 0 after bit 31 is sampled; the next rising
                // edge ends bit 31 and releases the line.
                S_RDATA: begin
                    if (mdc_fall_c) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end else if (mdc_rise_c) begin
                        if (bit_cnt[4]) begin
                            mdio_oe  <= 1'b1;
                            mdio_out <= tx_shift[DATA_W-1];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        end else if (bit_cnt == '0) begin
                            mdio_oe  <= 1'b0;
                            mdio_out <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end

                S_SKIP: begin
                    if (mdc_fall_c) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: an MDIO master model drives frames, a scoreboard
// matches strobes, and the master checks read data and drive windows.
module tb_mdio_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mdc = 1'b0;
    logic        mdio_drv = 1'b1;
    logic        mdio_line;
    logic        mdio_out;
    logic        mdio_oe;
    logic [4:0]  reg_addr;
    logic [15:0] wr_data;
    logic        wr_stb;
    logic        rd_stb;
    logic [15:0] rd_data = 16'hDEAD;

    mdio_responder #(.PHY_ADDR(5'd1)) dut (
        .clk      (clk),
        .reset    (reset),
        .mdc      (mdc),
        .mdio_in  (mdio_line),
        .mdio_out (mdio_out),
        .mdio_oe  (mdio_oe),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .wr_stb   (wr_stb),
        .rd_stb   (rd_stb),
        .rd_data  (rd_data)
    );

    assign mdio_line = mdio_oe ? mdio_out : mdio_drv;

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [4:0]  addr;
        logic [15:0] data;
    } sb_t;

    typedef struct {
        logic [31:0] frame;
        logic [15:0] rd_val;
        int          kind;      // 0 none, 1 write strobe, 2 read strobe
        logic [4:0]  exp_addr;
        logic [15:0] exp_data;
        int          exp_oe;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[9];
    int          n_cmp = 0;
    int          n_err = 0;
    int          oe_cnt = 0;
    int          oe_early = 0;
    int          cur_bit = 99;
    logic [15:0] rd_ret = 16'h0000;
    logic [15:0] rx = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic is_wr, input logic [4:0] addr, input logic [15:0] data);
        sb_t e;
        e.is_wr = is_wr;
        e.addr  = addr;
        e.data  = data;
        sb.push_back(e);
    endtask

    // Register-bank model plus strobe scoreboard and drive-window monitor.
    always @(negedge clk) begin
        if (mdio_oe) begin
            oe_cnt++;
            if (cur_bit >= 1 && cur_bit <= 15) oe_early++;
        end
        if (rd_stb) rd_data = rd_ret;
        if (wr_stb || rd_stb) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: wr_stb=%0b rd_stb=%0b reg_addr=%0d, expected none", wr_stb, rd_stb, reg_addr);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("stb_kind_is_wr", 32'(wr_stb), 32'(e.is_wr));
                check("stb_rd", 32'(rd_stb), 32'(!e.is_wr));
                check("stb_addr", 32'(reg_addr), 32'(e.addr));
                if (e.is_wr) check("stb_wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_bits(input int n);
        for (int k = 0; k < n; k++) begin
            mdc = 1'b1;
            cur_bit = 99;
            mdio_drv = 1'b1;
            #50 mdc = 1'b0;
            #50;
        end
    endtask

    // Master side: changes MDIO on MDC rise, releases the line from TA on reads,
    // and samples returned data at the end of each data bit. abort_bit >= 0
    // pulses reset during that bit and abandons the frame.
    task automatic send_frame(input logic [31:0] frame, input int abort_bit);
        logic rd_op;
        rd_op = (frame[29:28] == 2'b10);
        rd_data = 16'hDEAD;
        rx = 16'h0000;
        for (int k = 0; k < 32; k++) begin
            mdc = 1'b1;
            cur_bit = k;
            mdio_drv = (rd_op && k >= 14) ? 1'b1 : frame[31-k];
            if (k == abort_bit) begin
                #30;
                @(negedge clk);
                check("oe_before_reset", 32'(mdio_oe), 32'd1);
                reset = 1'b1;
                @(negedge clk);
                check("rst_mdio_oe", 32'(mdio_oe), 32'd0);
                check("rst_mdio_out", 32'(mdio_out), 32'd0);
                check("rst_reg_addr", 32'(reg_addr), 32'd0);
                check("rst_wr_data", 32'(wr_data), 32'd0);
                check("rst_strobes", 32'({wr_stb, rd_stb}), 32'd0);
                reset = 1'b0;
                cur_bit = 99;
                mdio_drv = 1'b1;
                return;
            end
            #50 mdc = 1'b0;
            #50;
            if (rd_op && k >= 16) rx = {rx[14:0], mdio_line};
        end
    endtask

    initial begin
        int oe0;

        vecs[0] = '{32'h508EBEEF, 16'h0000, 1, 5'd3,  16'hBEEF, 0};
        vecs[1] = '{32'h608E0000, 16'h1234, 2, 5'd3,  16'h0000, 160};
        vecs[2] = '{32'h510EBEEF, 16'h0000, 0, 5'd3,  16'h0000, 0};
        vecs[3] = '{32'h508A5A5A, 16'h0000, 1, 5'd2,  16'h5A5A, 0};
        vecs[4] = '{32'h610E0000, 16'h7777, 0, 5'd2,  16'h0000, 0};
        vecs[5] = '{32'h60FE0000, 16'h8001, 2, 5'd31, 16'h0000, 160};
        vecs[6] = '{32'h50820000, 16'h0000, 1, 5'd0,  16'h0000, 0};
        vecs[7] = '{32'h708E1111, 16'h0000, 0, 5'd0,  16'h0000, 0};
        vecs[8] = '{32'h408E1111, 16'h0000, 0, 5'd0,  16'h0000, 0};

        repeat (4) @(negedge clk);
        check("reset_mdio_oe", 32'(mdio_oe), 32'd0);
        check("reset_mdio_out", 32'(mdio_out), 32'd0);
        check("reset_reg_addr", 32'(reg_addr), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        check("reset_strobes", 32'({wr_stb, rd_stb}), 32'd0);
        reset = 1'b0;
        align();
        idle_bits(2);

        for (int i = 0; i < 9; i++) begin
            rd_ret = vecs[i].rd_val;
            if (vecs[i].kind != 0) push_exp(vecs[i].kind == 1, vecs[i].exp_addr, vecs[i].exp_data);
            oe0 = oe_cnt;
            send_frame(vecs[i].frame, -1);
            idle_bits(2);
            check($sformatf("v%0d_reg_addr", i), 32'(reg_addr), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d_oe_cycles", i), 32'(oe_cnt - oe0), 32'(vecs[i].exp_oe));
            check($sformatf("v%0d_sb_drained", i), 32'(sb.size()), 32'd0);
            if (vecs[i].kind == 1)
                check($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].exp_data));
            if (vecs[i].frame[29:28] == 2'b10)
                check($sformatf("v%0d_rx_word", i), 32'(rx),
                      32'((vecs[i].kind == 2) ? vecs[i].rd_val : 16'hFFFF));
        end

        // Reset during data bit 20 of a read, then a clean write.
        rd_ret = 16'h4321;
        push_exp(1'b0, 5'd3, 16'h0000);
        send_frame(32'h608E0000, 20);
        align();
        idle_bits(2);
        check("post_rst_sb_drained", 32'(sb.size()), 32'd0);
        check("post_rst_oe", 32'(mdio_oe), 32'd0);
        push_exp(1'b1, 5'd3, 16'h00AA);
        send_frame(32'h508E00AA, -1);
        idle_bits(2);
        check("post_rst_wr_data", 32'(wr_data), 32'h00AA);
        check("post_rst_reg_addr", 32'(reg_addr), 32'd3);
        check("post_rst_wr_drained", 32'(sb.size()), 32'd0);

        // Idle ones, then write immediately followed by read.
        idle_bits(8);
        push_exp(1'b1, 5'd3, 16'hBEEF);
        oe0 = oe_cnt;
        send_frame(32'h508EBEEF, -1);
        rd_ret = 16'hCAFE;
        push_exp(1'b0, 5'd3, 16'h0000);
        send_frame(32'h608E0000, -1);
        idle_bits(2);
        check("b2b_rx_word", 32'(rx), 32'hCAFE);
        check("b2b_oe_cycles", 32'(oe_cnt - oe0), 32'd160);
        check("b2b_sb_drained", 32'(sb.size()), 32'd0);
        check("b2b_wr_data", 32'(wr_data), 32'hBEEF);

        check("oe_during_bits_0_15", 32'(oe_early), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
